// File: rtl/button_pkg.sv
// button_pkg
//   Shared definitions for the push-button conditioner:
//   - button index constants (which physical button drives which command)
//   - repeat-FSM state encoding
//   - popcount helper for the press tally
package button_pkg;

  localparam int NUM_BTN   = 4;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_RESET = 2;
  localparam int BTN_AUX   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce
//   One push-button channel: 2-FF synchronizer, debounce counter, debounced
//   level and single-cycle press/release pulses.
//   Ports:
//     clk1          in   system clock
//     reset         in   synchronous, active-high reset
//     raw           in   raw button pin, active-low, asynchronous
//     level         out  debounced level, 1 = pressed
//     press         out  one-cycle pulse when a press is accepted
//     release_pulse out  one-cycle pulse when a release is accepted
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 26
) (
  input  logic clk1,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             s;
  logic [CNT_W-1:0] cnt;

  // Stage p0/p1: synchronizer, reset to the released (high) pin level
  always_ff @(posedge clk1) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  assign s = ~sync_p1;

  // Stage p2: debounce; any sample agreeing with the stable level restarts
  // the count, so only an uninterrupted run of DEBOUNCE_CYCLES is accepted
  always_ff @(posedge clk1) begin
    if (reset) begin
      cnt           <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt           <= '0;
        level         <= s;
        press         <= s;
        release_pulse <= ~s;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner
//   Conditions the four active-low board buttons, merges button presses with
//   the TriggerIn 0x40 command pulses into one up/down/reset command stream
//   for count1, and keeps a 16-bit tally of accepted presses.
//   Optional feature macro: BUTTON_AUTOREPEAT_EN -- when defined, holding
//   exactly one of the up/down buttons produces auto-repeat commands.
//   Ports:
//     clk1         in   system clock
//     reset        in   synchronous, active-high reset
//     button[3:0]  in   raw buttons, active-low (0=up 1=down 2=reset 3=aux)
//     trig_reset   in   TriggerIn bit 0 pulse
//     trig_up      in   TriggerIn bit 1 pulse
//     trig_down    in   TriggerIn bit 2 pulse
//     btn_level    out  debounced levels, 1 = pressed
//     btn_press    out  accepted-press pulses
//     btn_release  out  accepted-release pulses
//     cnt_reset/cnt_up/cnt_down  out  merged one-hot-or-zero commands
//     press_count  out  wrapping tally of accepted presses
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 26
) (
  input  logic        clk1,
  input  logic        reset,
  input  logic [3:0]  button,
  input  logic        trig_reset,
  input  logic        trig_up,
  input  logic        trig_down,
  output logic [3:0]  btn_level,
  output logic [3:0]  btn_press,
  output logic [3:0]  btn_release,
  output logic        cnt_reset,
  output logic        cnt_up,
  output logic        cnt_down,
  output logic [15:0] press_count
);

  logic rep_up;
  logic rep_down;
  logic req_reset;
  logic req_up;
  logic req_down;
  logic unused_cfg;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk1         (clk1),
      .reset        (reset),
      .raw          (button[i]),
      .level        (btn_level[i]),
      .press        (btn_press[i]),
      .release_pulse(btn_release[i])
    );
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  rep_state_t       state;
  rep_state_t       state_nxt;
  logic [CNT_W-1:0] rcnt;
  logic [CNT_W-1:0] rcnt_nxt;
  logic             one_held;
  logic             rep_fire;

  // Holding both up and down is treated like holding neither
  assign one_held = btn_level[BTN_UP] ^ btn_level[BTN_DOWN];

  always_ff @(posedge clk1) begin
    if (reset) begin
      state <= IDLE;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = '0;
    rep_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (one_held) state_nxt = DELAY;
      end
      DELAY: begin
        if (!one_held) begin
          state_nxt = IDLE;
        end else if (rcnt == DELAY_LAST) begin
          rep_fire  = 1'b1;
          state_nxt = REPEAT;
        end else begin
          rcnt_nxt = rcnt + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (!one_held) begin
          state_nxt = IDLE;
        end else if (rcnt == PERIOD_LAST) begin
          rep_fire = 1'b1;
        end else begin
          rcnt_nxt = rcnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    rep_up   = rep_fire & btn_level[BTN_UP];
    rep_down = rep_fire & btn_level[BTN_DOWN];
  end

  assign unused_cfg = BTN_AUX[0];
`else
  assign rep_up     = 1'b0;
  assign rep_down   = 1'b0;
  assign unused_cfg = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0], BTN_AUX[0]};
`endif

  // Reset wins; simultaneous up and down cancel out
  always_comb begin
    req_reset = trig_reset | btn_press[BTN_RESET];
    req_up    = trig_up | btn_press[BTN_UP] | rep_up;
    req_down  = trig_down | btn_press[BTN_DOWN] | rep_down;
    cnt_reset = 1'b0;
    cnt_up    = 1'b0;
    cnt_down  = 1'b0;
    if (req_reset) begin
      cnt_reset = 1'b1;
    end else if (req_up ^ req_down) begin
      cnt_up   = req_up;
      cnt_down = req_down;
    end
  end

  // Tally stage: counts only debounced presses, never repeats or triggers
  always_ff @(posedge clk1) begin
    if (reset) begin
      press_count <= '0;
    end else begin
      press_count <= press_count + 16'(popcount4(btn_press));
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  logic        clk1 = 1'b0;
  logic        reset;
  logic [3:0]  button;
  logic        trig_reset, trig_up, trig_down;
  logic [3:0]  btn_level, btn_press, btn_release;
  logic        cnt_reset, cnt_up, cnt_down;
  logic [15:0] press_count;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state (values visible during the current cycle)
  logic [3:0]  m_d0, m_d1, m_level, m_press, m_rel;
  logic [3:0]  m_hist [D];
  logic [15:0] m_count;
  int          m_run;

  always #5 clk1 = ~clk1;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .CNT_W          (26)
  ) dut (
    .clk1       (clk1),
    .reset      (reset),
    .button     (button),
    .trig_reset (trig_reset),
    .trig_up    (trig_up),
    .trig_down  (trig_down),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .cnt_reset  (cnt_reset),
    .cnt_up     (cnt_up),
    .cnt_down   (cnt_down),
    .press_count(press_count)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // A level change is accepted once the last D synchronized samples all
  // disagree with the current level.
  task automatic model_step();
    logic all_diff;
    if (reset) begin
      m_d0 = 4'hF; m_d1 = 4'hF;
      m_level = '0; m_press = '0; m_rel = '0;
      for (int k = 0; k < D; k++) m_hist[k] = '0;
      m_count = '0;
      m_run = -1;
    end else begin
      m_count = m_count + 16'($countones(m_press));
      for (int k = D - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = ~m_d1;
      m_press = '0; m_rel = '0;
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        for (int k = 0; k < D; k++)
          if (m_hist[k][i] == m_level[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[i] = ~m_level[i];
          m_press[i] = m_level[i];
          m_rel[i]   = ~m_level[i];
        end
      end
      m_d1 = m_d0;
      m_d0 = button;
      if ($countones(m_level[1:0]) == 1) m_run = (m_run >= 0) ? m_run + 1 : 0;
      else m_run = -1;
    end
  endtask

  task automatic compare_model();
    logic fire, ru, rd, q_r, q_u, q_d;
    logic [2:0] exp_cmd;
`ifdef BUTTON_AUTOREPEAT_EN
    fire = (m_run >= RD) && (((m_run - RD) % RP) == 0);
`else
    fire = 1'b0;
`endif
    ru  = fire & m_level[0];
    rd  = fire & m_level[1];
    q_r = trig_reset | m_press[2];
    q_u = trig_up | m_press[0] | ru;
    q_d = trig_down | m_press[1] | rd;
    if (q_r) exp_cmd = 3'b100;
    else if (q_u && !q_d) exp_cmd = 3'b010;
    else if (q_d && !q_u) exp_cmd = 3'b001;
    else exp_cmd = 3'b000;
    check("level", 32'(btn_level), 32'(m_level));
    check("press", 32'(btn_press), 32'(m_press));
    check("release", 32'(btn_release), 32'(m_rel));
    check("cmd", 32'({cnt_reset, cnt_up, cnt_down}), 32'(exp_cmd));
    check("count", 32'(press_count), 32'(m_count));
  endtask

  task automatic apply(input logic [3:0] b, input logic r, input logic tr,
                       input logic tu, input logic td);
    button = b; reset = r; trig_reset = tr; trig_up = tu; trig_down = td;
    #1;
    compare_model();
  endtask

  task automatic tick();
    @(posedge clk1);
    model_step();
    @(negedge clk1);
  endtask

  task automatic idle(input int n, input logic [3:0] b);
    for (int k = 0; k < n; k++) begin
      apply(b, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    logic [15:0] base;
    logic [3:0]  rb;
    int          hold [4];

    button = 4'hF; reset = 1'b1;
    trig_reset = 1'b0; trig_up = 1'b0; trig_down = 1'b0;
    repeat (3) begin
      @(posedge clk1);
      model_step();
    end
    @(negedge clk1);

    // Out of reset: everything quiet
    for (int k = 0; k < 12; k++) begin
      apply(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rst_level", 32'(btn_level), 32'h0);
      check("rst_pulse", 32'({btn_press, btn_release}), 32'h0);
      check("rst_cmd", 32'({cnt_reset, cnt_up, cnt_down}), 32'h0);
      check("rst_count", 32'(press_count), 32'h0);
      tick();
    end

    // Single up press: accepted exactly 10 cycles after the edge
    for (int k = 0; k < 14; k++) begin
      apply(4'b1110, 1'b0, 1'b0, 1'b0, 1'b0);
      check("up_press", 32'(btn_press[0]), 32'(k == 10));
      check("up_cmd", 32'(cnt_up), 32'(k == 10));
      tick();
    end
    check("up_count", 32'(press_count), 32'd1);
    for (int k = 0; k < 14; k++) begin
      apply(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
      check("up_release", 32'(btn_release[0]), 32'(k == 10));
      tick();
    end

    // Bouncy down button: 5 low, 1 high, never accepted
    for (int k = 0; k < 36; k++) begin
      apply((k % 6 == 5) ? 4'hF : 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);
      check("glitch_level", 32'(btn_level[1]), 32'h0);
      check("glitch_press", 32'(btn_press[1]), 32'h0);
      tick();
    end
    idle(12, 4'hF);

    // Trigger merging
    apply(4'hF, 1'b0, 1'b0, 1'b1, 1'b1);
    check("trig_updown", 32'({cnt_reset, cnt_up, cnt_down}), 32'h0);
    tick();
    apply(4'hF, 1'b0, 1'b1, 1'b1, 1'b0);
    check("trig_rst_up", 32'({cnt_reset, cnt_up, cnt_down}), 32'b100);
    tick();
    apply(4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    check("trig_down", 32'({cnt_reset, cnt_up, cnt_down}), 32'b001);
    tick();

    // Buttons 0, 2, 3 together
    base = m_count;
    for (int k = 0; k < 14; k++) begin
      apply(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 10) begin
        check("multi_rst", 32'(cnt_reset), 32'h1);
        check("multi_up", 32'(cnt_up), 32'h0);
        check("multi_press", 32'(btn_press), 32'b1101);
      end
      tick();
    end
    check("multi_count", 32'(press_count), 32'(base + 16'd3));
    idle(14, 4'hF);

    // Tally wrap
    force dut.press_count = 16'hFFFF;
    #1;
    release dut.press_count;
    m_count = 16'hFFFF;
    idle(14, 4'b0111);
    check("wrap_count", 32'(press_count), 32'h0);
    idle(14, 4'hF);

    // Reset mid-debounce aborts; the held button is re-debounced afterwards
    idle(5, 4'b1110);
    apply(4'b1110, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 14; k++) begin
      apply(4'b1110, 1'b0, 1'b0, 1'b0, 1'b0);
      check("abort_press", 32'(btn_press[0]), 32'(k == 10));
      tick();
    end
    check("abort_count", 32'(press_count), 32'h1);
    idle(14, 4'hF);

`ifdef BUTTON_AUTOREPEAT_EN
    // Auto-repeat on a held up button, cancelled by also holding down
    for (int k = 0; k < 70; k++) begin
      apply(4'b1110, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rep_up", 32'(cnt_up), 32'(k == 10 || (k >= 30 && ((k - 30) % 5) == 0)));
      tick();
    end
    for (int k = 0; k < 40; k++) begin
      apply(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);
      if (k > 10) check("rep_stop", 32'({cnt_up, cnt_down}), 32'h0);
      tick();
    end
    idle(14, 4'hF);
`endif

    // Randomized buttons, triggers and occasional resets
    rb = 4'hF;
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int n = 0; n < 5000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          rb[i] = ~rb[i];
          hold[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 9) : $urandom_range(10, 70);
        end else begin
          hold[i]--;
        end
      end
      apply(rb, $urandom_range(0, 399) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the four raw, active-low board push-buttons into clean clk1-domain levels and single-cycle press/release pulses. It merges the up/down/reset button pulses with the TriggerIn command pulses into one command stream for the up/down counter (count1). It also keeps a press-event tally for host read-back through a WireOut. It sits between the button pins / okTriggerIn 0x40 outputs and the count1 logic.

## Interface
- DEBOUNCE_CYCLES, 50000: cycles a synchronized level must hold before it is accepted (≥2).
- REPEAT_DELAY, 25000000: hold cycles before the first auto-repeat pulse.
- REPEAT_PERIOD, 5000000: cycles between later auto-repeat pulses.
- CNT_W, 26: width of the internal debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).
- clk1  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- button  in  4  raw buttons, active-low, asynchronous.
- trig_reset / trig_up / trig_down  in  1 each  one-cycle pulses from TriggerIn 0x40 bits [0]/[1]/[2], already in the clk1 domain.
- btn_level  out  4  debounced level, 1 = pressed.
- btn_press  out  4  one-cycle pulse on an accepted press.
- btn_release  out  4  one-cycle pulse on an accepted release.
- cnt_reset / cnt_up / cnt_down  out  1 each  merged counter commands; at most one is high in any cycle.
- press_count  out  16  running count of accepted presses on all buttons.

## Operation
- Per button, the raw input passes through a 2-FF synchronizer and is inverted to give `s`.
- Debounce per button:
  - If `s` == stable state: counter = 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the stable state takes `s`, the counter clears, and btn_press or btn_release pulses for one cycle.
  - A glitch shorter than DEBOUNCE_CYCLES resets the counter. It produces no pulse.
- Button mapping: button[0] = up, button[1] = down, button[2] = reset, button[3] = aux (level, pulses and tally only).
- Command merge:
  - req_reset = trig_reset | btn_press[2]
  - req_up = trig_up | btn_press[0] | rep_up
  - req_down = trig_down | btn_press[1] | rep_down
  - If req_reset is high: cnt_reset = 1 and up/down are dropped.
  - Else if req_up and req_down are both high: no command (net zero).
  - Else the single active request is passed through.
- press_count adds popcount(btn_press) every cycle and wraps modulo 2^16. It is cleared only by reset; trig_reset does not clear it.
- Reset values:
  - Synchronizer FFs = 1 (released).
  - Stable states = 0, so no pulse comes out of reset.
  - All pulses and commands = 0.
  - press_count = 0.
  - Counters = 0.
  - Repeat FSM = IDLE.
- Reset asserted mid-debounce or mid-repeat aborts the operation and emits no pulse. Any button still held after reset is re-debounced and then reported as a fresh press.

## Timing
- Raw edge to btn_press/btn_release: 2 synchronizer cycles + DEBOUNCE_CYCLES cycles, then one registered output cycle.
- btn_press to cnt_*: same cycle (combinational merge).
- trig_* to cnt_*: same cycle. All cnt_* outputs are one cycle wide.
- btn_level changes in the same cycle as its press/release pulse.
- press_count updates one cycle after the pulse.

## Configuration
- Macro: BUTTON_AUTOREPEAT_EN.
- Defined: a repeat FSM runs for buttons 0 and 1.
  - IDLE → DELAY when exactly one of btn_level[1:0] is high.
  - DELAY → REPEAT after REPEAT_DELAY cycles, emitting rep_up or rep_down for one cycle.
  - In REPEAT, a pulse is emitted every REPEAT_PERIOD cycles.
  - Any state → IDLE when the held button releases or both buttons are held.
  - Repeat pulses do not increment press_count.
- Undefined: no FSM logic is built; rep_up = rep_down = 0; REPEAT_DELAY and REPEAT_PERIOD are ignored.

## Structure
- Shared package `button_pkg` holds:
  - Button index constants: BTN_UP=0, BTN_DOWN=1, BTN_RESET=2, BTN_AUX=3.
  - The repeat-FSM state enum: IDLE, DELAY, REPEAT.
- One sub-module, `button_debounce`, contains the synchronizer, debounce counter, level and edge pulses for one button. It is instantiated 4× with generate.

## Test plan
All runs use DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5.
- Assert reset with all buttons released, then release reset → all outputs are 0 and press_count = 0; no pulse follows.
- Drive button[0] low and hold → btn_press[0] and cnt_up pulse exactly once, 10 cycles after the edge; press_count = 1. Release → btn_release[0] pulses once.
- Drive button[1] low for 5 cycles, high for 1 cycle, repeated → no pulse ever; btn_level[1] stays 0.
- Pulse trig_up and trig_down in the same cycle → no cnt_* output. Pulse trig_reset together with trig_up → cnt_reset only.
- Press buttons 0, 2 and 3 simultaneously → press_count increments by 3; cnt_reset = 1 and cnt_up = 0. Then, with press_count forced to 0xFFFF, one more press → press_count = 0x0000.
- With BUTTON_AUTOREPEAT_EN defined, hold button[0] for 50 cycles after acceptance → the initial cnt_up, then repeats at +20, +25, +30, …. Pressing button[1] while button[0] is held → repeats stop.
